dat_read_crc16: RTL
===================

# dat_read_crc16

Receive-side DAT-line framer and CRC16 checker for single-bit SD bus block reads. Waits for the start bit, forwards the block's data bits to the read data path, runs the bits through CRC16-CCITT, checks the 16 trailing CRC bits and the end bit, and reports a one-cycle completion with error flags. It is the read-direction counterpart of the write-path CRC16 generator and sits between the DAT pad sampler and the read buffer packer.

## Interface
- `TimeoutSamples`, default 65535: number of sample strobes to wait for a start bit before `timeout_o`. Used only with `SDHCI_DAT_READ_TIMEOUT_EN`.
- `clk_i`  in  1  system clock; the single clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `sample_en_i`  in  1  one-cycle strobe per SD clock; `dat_ser_i` is evaluated only on these cycles.
- `dat_ser_i`  in  1  DAT0 line level, already synchronised.
- `start_i`  in  1  arm the receiver; honoured only in IDLE.
- `abort_i`  in  1  cancel any operation; return to IDLE.
- `block_len_i`  in  12  block length in bytes, 1..2048; latched on an accepted `start_i`.
- `busy_o`  out  1  high whenever the state is not IDLE.
- `data_valid_o`  out  1  one-cycle pulse per received data bit.
- `data_bit_o`  out  1  data bit, valid with `data_valid_o`, MSB of each byte first.
- `done_o`  out  1  one-cycle pulse when a block is finished.
- `crc_err_o`  out  1  valid with `done_o`; CRC remainder was not 0.
- `end_err_o`  out  1  valid with `done_o`; end bit was sampled as 0.
- `timeout_o`  out  1  one-cycle pulse when the start-bit wait expires.

## Operation
- The states are IDLE, WAIT_START, DATA, CRC and END.
- IDLE: when `start_i` is high and `block_len_i` is not 0, latch the length, clear the CRC register to 0x0000 and go to WAIT_START. When `block_len_i` is 0, `start_i` is ignored.
- WAIT_START: on each strobe where `dat_ser_i` is 0 (the start bit), go to DATA with the bit counter at `block_len*8`.
- DATA: on each strobe, output the bit and update the CRC. The update is `fb = bit ^ crc[15]` and `crc = {crc[14:0],0} ^ (fb ? 16'h1021 : 0)`. After the last bit, go to CRC with the counter at 16.
- CRC: on each strobe, feed the received CRC bit (MSB first) through the same update. No `data_valid_o` pulses occur in this state. After 16 bits, go to END.
- END: on the next strobe, sample the end bit. Pulse `done_o` with `crc_err_o = (crc != 0)` and `end_err_o = ~dat_ser_i`, then go to IDLE.
- Width rules:
  - The bit counter is 15 bits (maximum 16384 bits).
  - The counter decrements on strobes only. The state transition occurs on the strobe where the counter reaches 1.
- `abort_i` has priority over every event. The next state is IDLE, with no `done_o` and no `timeout_o`. If `abort_i` and `start_i` occur in the same cycle, the abort wins.
- `start_i` while `busy_o` is high is ignored. `block_len_i` changes after the latch have no effect.
- `rst_i` asserted at any time, including mid-block:
  - The state is forced to IDLE and the CRC register to 0.
  - All outputs are 0 while reset is asserted and on the first cycle after.

## Timing
- All outputs are registered. Every output resets to 0.
- `data_valid_o`/`data_bit_o` assert in the cycle after the strobe that sampled the bit.
- `done_o` and the error flags assert in the cycle after the end-bit strobe. `busy_o` is low in that same cycle.
- `busy_o` rises in the cycle after an accepted `start_i`.
- Strobes may be back-to-back (every cycle) or arbitrarily spaced; behaviour is identical apart from timing.
- A start bit can be detected on the first strobe after arming.
- Total strobes from the start bit to the end bit inclusive: `1 + 8*len + 16 + 1`.

## Configuration
- Macro: `SDHCI_DAT_READ_TIMEOUT_EN`.
- Defined: WAIT_START counts strobes. When the count reaches `TimeoutSamples` without a start bit, the block pulses `timeout_o` for one cycle and returns to IDLE; `done_o` does not pulse. The count is cleared on entering WAIT_START.
- Not defined: no counter is built, `timeout_o` is tied to 0, and WAIT_START waits indefinitely.

## Test plan
- len=512, 4096 data bits of 1, then CRC 0x7FA1 and end bit 1 -> 4096 `data_valid_o` pulses all with bit 1; `done_o` asserts with `crc_err_o`=0 and `end_err_o`=0.
- Same block with CRC 0x7FA0 -> `done_o` asserts with `crc_err_o`=1.
- Same block with end bit 0 -> `end_err_o`=1 and `crc_err_o`=0.
- len=1, byte 0x00 with CRC 0x0000, `sample_en_i` every 3rd cycle, line held at 1 for 10 strobes before the start bit -> 8 `data_valid_o` pulses of 0; `done_o` asserts with `crc_err_o`=0.
- `rst_i` pulsed after 100 data bits; then `start_i` issued again with a full block -> all outputs are 0 during reset, and the second block completes with no errors.
- With the macro defined and `TimeoutSamples`=8, line held at 1 -> one `timeout_o` pulse after the 8th strobe and `busy_o` goes to 0. Without the macro, `busy_o` stays at 1.

Source files
------------

// File: rtl/dat_read_crc16.sv
// Receive-side SD DAT0 framer: start-bit hunt, data forwarding, CRC16-CCITT check, end-bit check.
// Optional start-bit timeout is built when SDHCI_DAT_READ_TIMEOUT_EN is defined.
module dat_read_crc16 #(
  parameter int unsigned TimeoutSamples = 65535
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        sample_en_i,
  input  logic        dat_ser_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [11:0] block_len_i,
  output logic        busy_o,
  output logic        data_valid_o,
  output logic        data_bit_o,
  output logic        done_o,
  output logic        crc_err_o,
  output logic        end_err_o,
  output logic        timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  state_t      state;
  logic [11:0] len_q;
  logic [14:0] bit_cnt;
  logic [15:0] crc;
  logic [15:0] crc_next;
  logic        fb;

  // Data bits and received CRC bits share one update; a matching CRC leaves a zero remainder.
  always_comb begin
    fb       = dat_ser_i ^ crc[15];
    crc_next = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  end

`ifdef SDHCI_DAT_READ_TIMEOUT_EN
  logic [31:0] tmo_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutSamples == 32'd0);
  assign timeout_o          = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      len_q        <= '0;
      bit_cnt      <= '0;
      crc          <= '0;
      busy_o       <= 1'b0;
      data_valid_o <= 1'b0;
      data_bit_o   <= 1'b0;
      done_o       <= 1'b0;
      crc_err_o    <= 1'b0;
      end_err_o    <= 1'b0;
`ifdef SDHCI_DAT_READ_TIMEOUT_EN
      tmo_cnt      <= '0;
      timeout_o    <= 1'b0;
`endif
    end else begin
      data_valid_o <= 1'b0;
      done_o       <= 1'b0;
      crc_err_o    <= 1'b0;
      end_err_o    <= 1'b0;
`ifdef SDHCI_DAT_READ_TIMEOUT_EN
      timeout_o    <= 1'b0;
`endif
      if (abort_i) begin
        state  <= S_IDLE;
        busy_o <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i && (block_len_i != 12'd0)) begin
              len_q  <= block_len_i;
              crc    <= '0;
              state  <= S_WAIT_START;
              busy_o <= 1'b1;
`ifdef SDHCI_DAT_READ_TIMEOUT_EN
              tmo_cnt <= '0;
`endif
            end
          end
          S_WAIT_START: begin
            if (sample_en_i) begin
              if (!dat_ser_i) begin
                state   <= S_DATA;
                bit_cnt <= {len_q, 3'b000};
              end
`ifdef SDHCI_DAT_READ_TIMEOUT_EN
              else if (tmo_cnt == TimeoutSamples - 32'd1) begin
                state     <= S_IDLE;
                busy_o    <= 1'b0;
                timeout_o <= 1'b1;
              end else begin
                tmo_cnt <= tmo_cnt + 32'd1;
              end
`endif
            end
          end
          S_DATA: begin
            if (sample_en_i) begin
              data_valid_o <= 1'b1;
              data_bit_o   <= dat_ser_i;
              crc          <= crc_next;
              if (bit_cnt == 15'd1) begin
                state   <= S_CRC;
                bit_cnt <= 15'd16;
              end else begin
                bit_cnt <= bit_cnt - 15'd1;
              end
            end
          end
          S_CRC: begin
            if (sample_en_i) begin
              crc <= crc_next;
              if (bit_cnt == 15'd1) begin
                state <= S_END;
              end else begin
                bit_cnt <= bit_cnt - 15'd1;
              end
            end
          end
          S_END: begin
            if (sample_en_i) begin
              done_o    <= 1'b1;
              crc_err_o <= (crc != 16'h0000);
              end_err_o <= ~dat_ser_i;
              state     <= S_IDLE;
              busy_o    <= 1'b0;
            end
          end
          default: begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
